fcvt_round_stage: RTL
=====================

Name: fcvt_round_stage

Overview:
Pipelined, correctly-rounding FP/integer conversion stage with the floating-point CSR (fcsr/frm/fflags) built in. It receives conversion ops (FUNC codes 7–10) from the decode/operand stage and delivers a rounded result plus per-op exception flags to writeback. It accumulates sticky fflags on retire and resolves the dynamic rounding mode from frm. It adds IEEE rounding modes, NX/NV flag generation and valid/ready backpressure to the existing single-cycle conversion path.

Parameters:
FFLAGS_ADDR, 12'h001, CSR address of fflags
FRM_ADDR, 12'h002, CSR address of frm
FCSR_ADDR, 12'h003, CSR address of fcsr

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  synchronous reset, active-high
IN_VALID  in  1  op offered
IN_READY  out  1  stage can accept op this cycle
A  in  32  source operand (integer or FP32 bit pattern)
FUNC  in  4  7=FCVT.S.W, 8=FCVT.W.S, 9=FCVT.S.WU, 10=FCVT.WU.S
RM  in  3  instruction rm field; 3'b111 = dynamic (use frm)
OUT_VALID  out  1  result available
OUT_READY  in  1  writeback accepts result
RESULT  out  32  converted value
FLAGS_OUT  out  5  per-op flags {NV,DZ,OF,UF,NX}
CSR_WE  in  1  CSR write strobe
CSR_ADDR  in  12  CSR address
CSR_WDATA  in  32  CSR write data
CSR_RDATA  out  32  CSR read data (combinational on CSR_ADDR)

Behaviour:
- Interface: one clock, CLK; reset RST is synchronous and active-high.
- Reset: stage-1/stage-2 valid=0, OUT_VALID=0, RESULT=0, FLAGS_OUT=0, fflags=0, frm=0. RST mid-operation discards in-flight ops; no flags are accumulated.
- Pipeline: two registered stages; latency 2 cycles from accept (IN_VALID&&IN_READY) to OUT_VALID; throughput 1 op/cycle.
- Stage 1: sign/magnitude extraction, leading-zero count, alignment shift, guard/round/sticky capture, rounding-mode resolve.
- Stage 2: rounding increment, renormalise, saturate, flag generation.
- Handshake: stage advances when downstream slot is empty or draining. IN_READY = !s1_valid || !s2_valid || OUT_READY (combinational). OUT_VALID holds, and RESULT/FLAGS_OUT stay stable, until OUT_READY. Op order is preserved; no op is dropped or duplicated.
- Rounding mode: RM 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM, 7 → frm sampled at accept. Frm written in the same cycle as accept: the old value is used. Resolved mode 5/6: RESULT=0, FLAGS_OUT=NV only.
- Int→FP (7, 9): FUNC 7 uses two's-complement magnitude; FUNC 9 uses A unsigned, sign 0. A=0 → +0.0. Exponent = 127+31−lzc. 24-bit significand rounded using G/R/S. A mantissa carry-out increments the exponent. NX when any discarded bit is set. NV/OF never set.
- FP→Int (8, 10), Exp = A[30:23]:
  - NaN: 0x7FFFFFFF (8) or 0xFFFFFFFF (10), NV.
  - +Inf: 0x7FFFFFFF (8) or 0xFFFFFFFF (10), NV.
  - −Inf: 0x80000000 (8) or 0 (10), NV.
  - Finite: shift to integer with G/R/S, round per mode.
  - Range (8): result must lie in [−2^31, 2^31−1]. Range (10): result must lie in [0, 2^32−1].
  - Out of range after rounding: saturate to the nearest bound, NV only (NX not set).
  - Negative operand rounding to 0 with FUNC 10: result 0, NX only (not NV).
  - Denormals are handled as tiny values.
- fflags update: on retire (OUT_VALID&&OUT_READY), next fflags = base | FLAGS_OUT. base = write data if this cycle's CSR write targets fflags/fcsr, else the current fflags (write first, then OR retiring flags).
- CSR write to frm/fcsr updates frm (fcsr: frm=WDATA[7:5], fflags=WDATA[4:0]).
- CSR_RDATA: fflags → {27'b0,fflags}; frm → {29'b0,frm}; fcsr → {24'b0,frm,fflags}; other addresses → 0.

Optional Feature:
CVT_PERF_CNT_EN
- Defined: two 32-bit wrapping counters, reset to 0. Retired ops → readable at 12'h7C0. Retired ops with NX or NV → readable at 12'h7C1. Read-only.
- Not defined: no counters; reads of 12'h7C0/12'h7C1 return 0.

Test Plan:
- FUNC=7, A=0x00000001, RM=0 → RESULT=0x3F800000, FLAGS_OUT=0, OUT_VALID exactly 2 cycles after accept.
- FUNC=7, A=0x01000001 → RM=0: 0x4B800000, NX. RM=3: 0x4B800001, NX. A=0x80000000 → 0xCF000000, no flags.
- FUNC=8, A=0x3FC00000 (1.5) → RM=0: 2, NX. RM=1: 1, NX. A=0x4F000000 → 0x7FFFFFFF, NV. A=0xCF000000 → 0x80000000, no flags.
- FUNC=10 → A=0xBF000000, RM=1: 0, NX. A=0xBF800000: 0, NV. A=0x7FC00000: 0xFFFFFFFF, NV.
- Backpressure: 3 back-to-back ops with OUT_READY=0 → IN_READY falls after 2 accepted; release → results retire in order, none lost.
- CSR: write frm=3, then FUNC=8, RM=7, A=1.5 → 2; fflags reads 0x01. CSR write fflags=0 in the same cycle as an NX retire → fflags=0x01.

Source files
------------

// File: rtl/fcvt_round_stage.sv
// fcvt_round_stage: two-stage, correctly-rounding FP32 <-> int32 conversion with fflags/frm/fcsr.
// Optional macro CVT_PERF_CNT_EN adds read-only retired/exception counters at 12'h7C0 / 12'h7C1.
module fcvt_round_stage #(
  parameter logic [11:0] FFLAGS_ADDR = 12'h001,
  parameter logic [11:0] FRM_ADDR    = 12'h002,
  parameter logic [11:0] FCSR_ADDR   = 12'h003
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [31:0] A,
  input  logic [3:0]  FUNC,
  input  logic [2:0]  RM,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] RESULT,
  output logic [4:0]  FLAGS_OUT,
  input  logic        CSR_WE,
  input  logic [11:0] CSR_ADDR,
  input  logic [31:0] CSR_WDATA,
  output logic [31:0] CSR_RDATA
);

  localparam logic [4:0] FL_NV = 5'b10000;

  function automatic logic [4:0] lzc32(input logic [31:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd0;
    found = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 5'(31 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  function automatic logic round_inc(input logic [2:0] rm, input logic sign, input logic lsb,
                                     input logic g, input logic r, input logic s);
    logic inc;
    case (rm)
      3'd0:    inc = g & (r | s | lsb);
      3'd2:    inc = sign & (g | r | s);
      3'd3:    inc = !sign & (g | r | s);
      3'd4:    inc = g;
      default: inc = 1'b0;
    endcase
    return inc;
  endfunction

  // Returns {flags, result}; an out-of-range value saturates with NV alone, never NX.
  function automatic logic [36:0] f2i_sat(input logic is_u, input logic sign, input logic huge,
                                          input logic [32:0] mag, input logic inexact);
    logic [31:0] res;
    logic [4:0]  fl;
    res = mag[31:0];
    fl  = {4'd0, inexact};
    if (is_u) begin
      if (sign) begin
        res = 32'd0;
        if (huge || mag != 33'd0) fl = FL_NV;
      end else if (huge || mag[32]) begin
        res = 32'hFFFF_FFFF;
        fl  = FL_NV;
      end
    end else if (sign) begin
      if (huge || mag > 33'h0_8000_0000) begin
        res = 32'h8000_0000;
        fl  = FL_NV;
      end else begin
        res = -mag[31:0];
      end
    end else if (huge || mag[32] || mag[31]) begin
      res = 32'h7FFF_FFFF;
      fl  = FL_NV;
    end
    return {fl, res};
  endfunction

  logic        vld_p1, vld_p2, adv1, adv2, retire;
  logic [4:0]  fflags;
  logic [2:0]  frm;

  logic [2:0]  rm_res;
  logic        is_i2f, is_u, func_ok, i_sign;
  logic signed [31:0] a_s;
  logic [31:0] i_mag, i_norm;
  logic [7:0]  f_exp, f_sh;
  logic [23:0] f_sig;
  logic [63:0] f_wide;

  assign adv2     = !vld_p2 || OUT_READY;
  assign adv1     = !vld_p1 || adv2;
  assign IN_READY = adv1;
  assign retire   = vld_p2 && OUT_READY;

  always_comb begin
    rm_res  = (RM == 3'd7) ? frm : RM;
    is_i2f  = (FUNC == 4'd7) || (FUNC == 4'd9);
    is_u    = (FUNC == 4'd9) || (FUNC == 4'd10);
    func_ok = (FUNC >= 4'd7) && (FUNC <= 4'd10);
    a_s     = $signed(A);
    i_sign  = (FUNC == 4'd7) && A[31];
    i_mag   = i_sign ? unsigned'(-a_s) : A;
    i_norm  = i_mag << lzc32(i_mag);
    f_exp   = A[30:23];
    f_sig   = {|f_exp, A[22:0]};
    f_sh    = f_exp - 8'd118;
    // Fixed point with 32 fraction bits: integer part [63:32], guard [31], round [30].
    f_wide  = {40'd0, f_sig} << f_sh[5:0];
    if (f_exp < 8'd118) f_wide = {63'd0, |f_sig};
  end

  // ---- stage 1: extraction, normalisation/alignment, G/R/S capture ----
  logic        is_i2f_p1, is_u_p1, ok_p1, badrm_p1, sign_p1, zero_p1;
  logic        nan_p1, inf_p1, huge_p1, g_p1, r_p1, s_p1;
  logic [2:0]  rm_p1;
  logic [7:0]  exp_p1;
  logic [31:0] mant_p1;

  always_ff @(posedge CLK) begin
    if (adv1 && IN_VALID) begin
      is_i2f_p1 <= is_i2f;
      is_u_p1   <= is_u;
      ok_p1     <= func_ok;
      rm_p1     <= rm_res;
      badrm_p1  <= (rm_res >= 3'd5);
      sign_p1   <= is_i2f ? i_sign : A[31];
      zero_p1   <= (i_mag == 32'd0);
      exp_p1    <= 8'd158 - {3'd0, lzc32(i_mag)};
      nan_p1    <= (f_exp == 8'hFF) && (A[22:0] != 23'd0);
      inf_p1    <= (f_exp == 8'hFF) && (A[22:0] == 23'd0);
      huge_p1   <= (f_exp >= 8'd159);
      mant_p1   <= is_i2f ? {8'd0, i_norm[31:8]} : f_wide[63:32];
      g_p1      <= is_i2f ? i_norm[7] : f_wide[31];
      r_p1      <= is_i2f ? i_norm[6] : f_wide[30];
      s_p1      <= is_i2f ? |i_norm[5:0] : |f_wide[29:0];
    end
  end

  logic        inc, inexact;
  logic [32:0] sum;
  logic [36:0] sat;
  logic [31:0] res_c;
  logic [4:0]  fl_c;

  always_comb begin
    inc     = round_inc(rm_p1, sign_p1, mant_p1[0], g_p1, r_p1, s_p1);
    inexact = g_p1 | r_p1 | s_p1;
    sum     = {1'b0, mant_p1} + {32'd0, inc};
    sat     = f2i_sat(is_u_p1, sign_p1, huge_p1, sum, inexact);
    res_c   = 32'd0;
    fl_c    = 5'd0;
    if (badrm_p1) begin
      fl_c = FL_NV;
    end else if (!ok_p1) begin
      fl_c = 5'd0;
    end else if (is_i2f_p1) begin
      if (!zero_p1) begin
        // A carry out of the 24-bit significand leaves 1.000..0 one binade up.
        res_c = {sign_p1, exp_p1 + {7'd0, sum[24]}, sum[24] ? 23'd0 : sum[22:0]};
        fl_c  = {4'd0, inexact};
      end
    end else if (nan_p1 || (inf_p1 && !sign_p1)) begin
      res_c = is_u_p1 ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
      fl_c  = FL_NV;
    end else if (inf_p1) begin
      res_c = is_u_p1 ? 32'd0 : 32'h8000_0000;
      fl_c  = FL_NV;
    end else begin
      res_c = sat[31:0];
      fl_c  = sat[36:32];
    end
  end

  // ---- stage 2: rounding, renormalise, saturate, flags ----
  logic [31:0] result_p2;
  logic [4:0]  flags_p2;

  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      result_p2 <= 32'd0;
      flags_p2  <= 5'd0;
    end else begin
      if (adv1) vld_p1 <= IN_VALID;
      if (adv2) begin
        vld_p2 <= vld_p1;
        if (vld_p1) begin
          result_p2 <= res_c;
          flags_p2  <= fl_c;
        end
      end
    end
  end

  assign OUT_VALID = vld_p2;
  assign RESULT    = result_p2;
  assign FLAGS_OUT = flags_p2;

  logic       wr_fflags;
  logic [4:0] fflags_base;
  logic       unused_wdata;

  assign wr_fflags    = CSR_WE && (CSR_ADDR == FFLAGS_ADDR || CSR_ADDR == FCSR_ADDR);
  assign fflags_base  = wr_fflags ? CSR_WDATA[4:0] : fflags;
  assign unused_wdata = ^CSR_WDATA[31:8];

  // CSR write lands first, then the retiring op's flags are OR'd on top.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fflags <= 5'd0;
      frm    <= 3'd0;
    end else begin
      fflags <= fflags_base | (retire ? flags_p2 : 5'd0);
      if (CSR_WE && CSR_ADDR == FRM_ADDR)       frm <= CSR_WDATA[2:0];
      else if (CSR_WE && CSR_ADDR == FCSR_ADDR) frm <= CSR_WDATA[7:5];
    end
  end

`ifdef CVT_PERF_CNT_EN
  logic [31:0] cnt_ret, cnt_exc;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_ret <= 32'd0;
      cnt_exc <= 32'd0;
    end else if (retire) begin
      cnt_ret <= cnt_ret + 32'd1;
      if (flags_p2[4] || flags_p2[0]) cnt_exc <= cnt_exc + 32'd1;
    end
  end
`endif

  always_comb begin
    CSR_RDATA = 32'd0;
    if (CSR_ADDR == FFLAGS_ADDR)    CSR_RDATA = {27'd0, fflags};
    else if (CSR_ADDR == FRM_ADDR)  CSR_RDATA = {29'd0, frm};
    else if (CSR_ADDR == FCSR_ADDR) CSR_RDATA = {24'd0, frm, fflags};
`ifdef CVT_PERF_CNT_EN
    else if (CSR_ADDR == 12'h7C0)   CSR_RDATA = cnt_ret;
    else if (CSR_ADDR == 12'h7C1)   CSR_RDATA = cnt_exc;
`endif
  end

endmodule
